// File: rtl/dm_unit_pkg.sv
// Shared constants for the data memory stage: access-type codes and default depth.
package dm_unit_pkg;
    localparam logic [2:0] MEM_W  = 3'd0;
    localparam logic [2:0] MEM_H  = 3'd1;
    localparam logic [2:0] MEM_HU = 3'd2;
    localparam logic [2:0] MEM_B  = 3'd3;
    localparam logic [2:0] MEM_BU = 3'd4;

    localparam int DM_DEPTH = 3072;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= MEM_BU;
    endfunction
endpackage

// File: rtl/dm_ext.sv
// Combinational lane logic: store byte enables, store-lane replication, load extension.
module dm_ext
    import dm_unit_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wrep,
    output logic [31:0] rext
);
    logic [15:0] hsel;
    logic [7:0]  bsel;

    assign hsel = lane[1] ? rword[31:16] : rword[15:0];
    assign bsel = rword[{lane, 3'b000} +: 8];

    always_comb begin
        be   = 4'b0000;
        wrep = wdata;
        rext = 32'h0;
        case (mem_op)
            MEM_W: begin
                be   = 4'b1111;
                rext = rword;
            end
            MEM_H, MEM_HU: begin
                be   = 4'b0011 << {lane[1], 1'b0};
                wrep = {2{wdata[15:0]}};
                rext = (mem_op == MEM_H) ? {{16{hsel[15]}}, hsel} : {16'h0, hsel};
            end
            MEM_B, MEM_BU: begin
                be   = 4'b0001 << lane;
                wrep = {4{wdata[7:0]}};
                rext = (mem_op == MEM_B) ? {{24{bsel[7]}}, bsel} : {24'h0, bsel};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/dm_unit.sv
// Data memory stage: word array, legality check, byte-merged synchronous stores.
// Define DM_LOG_EN to print one line per committed store.
module dm_unit
    import dm_unit_pkg::*;
#(
    parameter int          DEPTH_WORDS = DM_DEPTH,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  mem_op,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        addr_err
);
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   word_off;
    logic [IW-1:0] widx;
    logic          misalign, oob, illegal;
    logic [31:0]   rword, rext, wrep, merged;
    logic [3:0]    be;
    logic          wr_en;

    assign word_off = (addr - ADDR_BASE) >> 2;
    assign widx     = word_off[IW-1:0];
    assign misalign = (mem_op == MEM_W && addr[1:0] != 2'b00) ||
                      ((mem_op == MEM_H || mem_op == MEM_HU) && addr[0]);
    // Underflow wraps word_off, so the base check must stand on its own.
    assign oob      = (addr < ADDR_BASE) || (word_off >= 32'(DEPTH_WORDS));
    assign illegal  = misalign || oob || !op_legal(mem_op);

    assign addr_err = !reset && illegal;
    assign rword    = illegal ? 32'h0 : mem[widx];
    assign rdata    = addr_err ? 32'h0 : (reset ? 32'h0 : rext);
    assign wr_en    = we && !illegal;

    dm_ext u_ext (
        .mem_op (mem_op),
        .lane   (addr[1:0]),
        .wdata  (wdata),
        .rword  (rword),
        .be     (be),
        .wrep   (wrep),
        .rext   (rext)
    );

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[i*8 +: 8] = be[i] ? wrep[i*8 +: 8] : rword[i*8 +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
        end else if (wr_en) begin
            mem[widx] <= merged;
        end
    end

`ifdef DM_LOG_EN
    always_ff @(posedge clk) begin
        if (!reset && wr_en)
            $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif
endmodule

// File: tb/tb_dm_unit.sv
// Directed vector bench for dm_unit: table of single-cycle accesses plus reset corner sequences.
`timescale 1ns/1ps
module tb_dm_unit;
    import dm_unit_pkg::*;

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, addr, wdata, rdata;
    logic [2:0]  mem_op;
    logic        we, addr_err;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vt[$];

    always #5 clk = ~clk;

    dm_unit dut (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .addr     (addr),
        .wdata    (wdata),
        .mem_op   (mem_op),
        .we       (we),
        .rdata    (rdata),
        .addr_err (addr_err)
    );

    function automatic void add(input logic w, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = w; v.op = op; v.addr = a; v.wdata = d; v.exp_rd = er; v.exp_err = ee;
        vt.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] er, input logic ee);
        n_vec++;
        if (rdata !== er || addr_err !== ee) begin
            n_bad++;
            $display("FAIL %s: rdata=%h addr_err=%b, want rdata=%h addr_err=%b",
                     name, rdata, addr_err, er, ee);
        end
    endtask

    task automatic drive(input logic w, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d);
        we = w; mem_op = op; addr = a; wdata = d; pc = pc + 32'd4;
    endtask

    initial begin
        reset = 1'b1; pc = 32'h0040_0000;
        drive(1'b0, MEM_W, 32'h0, 32'h0);

        // Reset held: outputs quiet even for an illegal access.
        #2 drive(1'b1, MEM_W, 32'h102, 32'hFFFF_FFFF);
        #1 check("reset_quiet", 32'h0, 1'b0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        add(0, MEM_W,  32'h0000, 32'h0,         32'h0,         0);
        add(0, MEM_W,  32'h0010, 32'h0,         32'h0,         0);
        add(0, MEM_W,  32'h2FFC, 32'h0,         32'h0,         0);
        add(0, MEM_W,  32'h0100, 32'h0,         32'h0,         0);   // array cleared despite store under reset
        add(1, MEM_W,  32'h0100, 32'h1234_5678, 32'h0,         0);   // old data during store
        add(0, MEM_W,  32'h0100, 32'h0,         32'h1234_5678, 0);
        add(1, MEM_B,  32'h0101, 32'h0000_00AB, 32'h0000_0056, 0);
        add(0, MEM_W,  32'h0100, 32'h0,         32'h1234_AB78, 0);
        add(1, MEM_H,  32'h0102, 32'h0000_80FF, 32'h0000_1234, 0);
        add(0, MEM_W,  32'h0100, 32'h0,         32'h80FF_AB78, 0);
        add(0, MEM_B,  32'h0101, 32'h0,         32'hFFFF_FFAB, 0);
        add(0, MEM_BU, 32'h0101, 32'h0,         32'h0000_00AB, 0);
        add(0, MEM_H,  32'h0102, 32'h0,         32'hFFFF_80FF, 0);
        add(0, MEM_HU, 32'h0102, 32'h0,         32'h0000_80FF, 0);
        add(0, MEM_BU, 32'h0103, 32'h0,         32'h0000_0080, 0);
        add(0, MEM_HU, 32'h0100, 32'h0,         32'h0000_AB78, 0);
        add(1, MEM_W,  32'h0102, 32'hFFFF_FFFF, 32'h0,         1);
        add(0, MEM_W,  32'h0100, 32'h0,         32'h80FF_AB78, 0);
        add(1, MEM_H,  32'h0103, 32'h0,         32'h0,         1);
        add(1, MEM_HU, 32'h0101, 32'h0,         32'h0,         1);
        add(0, MEM_W,  32'h0100, 32'h0,         32'h80FF_AB78, 0);
        add(1, MEM_W,  32'h3000, 32'h5555_5555, 32'h0,         1);
        add(0, MEM_W,  32'h0000, 32'h0,         32'h0,         0);
        add(1, MEM_W,  32'h2FFC, 32'hCAFE_F00D, 32'h0,         0);
        add(0, MEM_W,  32'h2FFC, 32'h0,         32'hCAFE_F00D, 0);
        add(0, MEM_BU, 32'h2FFF, 32'h0,         32'h0000_00CA, 0);
        add(1, 3'd6,   32'h0100, 32'h0,         32'h0,         1);
        add(1, 3'd5,   32'h0100, 32'h0,         32'h0,         1);
        add(1, 3'd7,   32'h0100, 32'h0,         32'h0,         1);
        add(0, MEM_W,  32'h0100, 32'h0,         32'h80FF_AB78, 0);
        add(0, MEM_W,  32'h0100, 32'h0,         32'h80FF_AB78, 0);   // we=0 store op below must not write
        add(0, MEM_W,  32'h0100, 32'h0BAD_0BAD, 32'h80FF_AB78, 0);
        add(0, MEM_W,  32'h0100, 32'h0,         32'h80FF_AB78, 0);
        add(1, MEM_B,  32'h0104, 32'h0000_0011, 32'h0,         0);   // back-to-back merges
        add(1, MEM_B,  32'h0105, 32'hFFFF_FF22, 32'h0,         0);
        add(1, MEM_H,  32'h0106, 32'h0000_A5C3, 32'h0,         0);
        add(0, MEM_W,  32'h0104, 32'h0,         32'hA5C3_2211, 0);
        add(0, MEM_B,  32'h0107, 32'h0,         32'hFFFF_FFA5, 0);

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].we, vt[i].op, vt[i].addr, vt[i].wdata);
            #1 check($sformatf("vec%0d", i), vt[i].exp_rd, vt[i].exp_err);
        end

        // Reset rising 1 ns before the edge of a store: reset wins.
        @(negedge clk);
        drive(1'b1, MEM_W, 32'h0200, 32'hDEAD_BEEF);
        #1 check("pre_rst_store", 32'h0, 1'b0);
        #3 reset = 1'b1;
        #0.5 check("rst_async_rd", 32'h0, 1'b0);
        @(posedge clk);
        #1 check("rst_edge", 32'h0, 1'b0);
        @(negedge clk);
        we = 1'b0;
        reset = 1'b0;
        addr = 32'h0200;
        #1 check("rst_store_lost", 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, MEM_W, 32'h0100, 32'h0);
        #1 check("rst_cleared_100", 32'h0, 1'b0);
        drive(1'b0, MEM_W, 32'h2FFC, 32'h0);
        #1 check("rst_cleared_2ffc", 32'h0, 1'b0);

        // Store after reset still works.
        @(negedge clk);
        drive(1'b1, MEM_W, 32'h0200, 32'h0000_0001);
        @(negedge clk);
        drive(1'b0, MEM_W, 32'h0200, 32'h0);
        #1 check("post_rst_store", 32'h0000_0001, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
- Data memory stage, directly downstream of the ALU.
- Consumes the ALU result as a byte address and serves lw/lh/lhu/lb/lbu/sw/sh/sb for the single-cycle datapath.
- Reads are combinational with load sign/zero extension; writes are synchronous with byte enables.
- Flags misaligned or out-of-range accesses so the controller can suppress writeback.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words stored.
- ADDR_BASE, 32'h0000_0000, byte address of word 0.

Ports:
- clk  input  1  system clock, rising edge active
- reset  input  1  asynchronous, active-high; clears the whole array
- pc  input  32  PC of the current instruction; used only by the write log
- addr  input  32  byte address, ALU result
- wdata  input  32  store data, rt value, right-aligned
- mem_op  input  3  access type: MEM_W=0, MEM_H=1, MEM_HU=2, MEM_B=3, MEM_BU=4; 5-7 are illegal
- we  input  1  store strobe from the controller
- rdata  output  32  extended load data
- addr_err  output  1  access illegal this cycle

Behaviour:
- Storage: DEPTH_WORDS x 32 array.
  - Word index = (addr - ADDR_BASE) >> 2.
  - Byte lane = addr[1:0], little-endian: lane 0 = bits [7:0].
- Reset (asynchronous, active-high):
  - All words become 0 immediately on reset assertion.
  - While reset is held: rdata = 0, addr_err = 0, and no write occurs.
  - Reset asserted in the same cycle as a store: reset wins, the word stays 0.
- Legality (combinational): addr_err = 1 when any of the following holds:
  - MEM_W with addr[1:0] != 0
  - MEM_H/MEM_HU with addr[0] != 0
  - addr < ADDR_BASE
  - word index >= DEPTH_WORDS
  - mem_op in 5-7
- Read path: combinational, zero latency, from the current array contents.
  - MEM_W: the full word.
  - MEM_H: sign-extended halfword, lane addr[1]*16.
  - MEM_HU: zero-extended halfword, same lane.
  - MEM_B: sign-extended byte, lane addr[1:0]*8.
  - MEM_BU: zero-extended byte, same lane.
  - addr_err = 1: rdata = 0.
- Write path: on the rising clk edge when we=1 and addr_err=0.
  - MEM_W: be=4'b1111, writes wdata.
  - MEM_H/MEM_HU: be=4'b0011 << addr[1]*2; writes wdata[15:0] replicated to both halves, only enabled lanes land.
  - MEM_B/MEM_BU: be=4'b0001 << addr[1:0]; writes wdata[7:0] replicated to all four bytes, only the enabled lane lands.
  - Unenabled bytes keep their old values.
- Store rules:
  - we=1 with addr_err=1: the array is unchanged and no log line is printed.
  - we=0: never writes, whatever mem_op is.
- Read-during-write: rdata in the store cycle shows the old data; the new data is visible after the edge.
- Back-to-back stores to the same word in consecutive cycles: both apply in order, byte merges accumulate.

Optional Feature:
- Macro: DM_LOG_EN.
- Defined: on every committed write, print $display("%d@%h: *%h <= %h", $time, pc, word_addr, merged_word).
  - word_addr = addr with bits [1:0] cleared.
  - merged_word = the full 32-bit word after the byte merge, in the grader's required format.
- Undefined: no display logic; functional behaviour is identical.

Decomposition:
- The MEM_* op codes and the DM_DEPTH default go in the team's shared global constants header, alongside the ALU function codes.
- One natural sub-module, dm_ext: a purely combinational block holding the byte-enable generator, store-lane replication and load extension.
- dm_unit holds the array, the legality check, the write sequencing and the log.

Test Plan:
- Reset then read: pulse reset, read MEM_W at 0x0, 0x10, 0x2FFC -> rdata=0, addr_err=0 at all three.
- Word round trip: sw 0x1234_5678 @0x100, next cycle lw @0x100 -> 0x12345678; with DM_LOG_EN, exactly one log line "*00000100 <= 12345678".
- Byte/half merge on the word at 0x100 (holding 0x12345678):
  - sb 0xAB @0x101 -> lw gives 0x1234AB78.
  - sh 0x80FF @0x102 -> lw gives 0x80FFAB78.
  - lb @0x101 -> 0xFFFFFFAB; lbu @0x101 -> 0x000000AB.
  - lh @0x102 -> 0xFFFF80FF; lhu @0x102 -> 0x000080FF.
- Misalign/range, each with we=1:
  - sw @0x102 -> addr_err=1, word 0x100 unchanged.
  - lh @0x103 -> addr_err=1, rdata=0.
  - sw @0x3000 (index 3072) -> addr_err=1, no write.
  - mem_op=6 -> addr_err=1.
- Reset mid-operation: store 0xDEADBEEF @0x200 with reset rising 1 ns before the clk edge -> word 0x200 reads 0 after reset deasserts; no log line printed.
